// File: rtl/exm_lane_sync_pkg.sv
// Shared definitions for the EXM lane completion barrier.
// Lane FSM encodings and the default ES->WS payload width.
// No logic; imported by the barrier top and its lane slots.
package exm_lane_sync_pkg;

   // Width of the ES->WS bus: {csr_wen, csr_addr, csr_wdata, gr_we, dest, result, pc}
   localparam int ES_TO_WS_BUS_WD = 117;
   localparam int PAYLOAD_W_DEF   = ES_TO_WS_BUS_WD;

   typedef enum logic [1:0] {
      LS_IDLE      = 2'b00,
      LS_WAIT_SELF = 2'b01,
      LS_HELD      = 2'b10
   } lane_state_t;

endpackage

// File: rtl/exm_lane_slot.sv
// One issue lane of the completion barrier: state FSM plus payload capture buffer.
// Capture takes one cycle; the release payload is combinational from buffer or live input.
// A lane that finishes before its group is told to hold until the group is accepted.
module exm_lane_slot
   import exm_lane_sync_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 grp_ready,
   input  logic                 valid,
   input  logic                 done,
   input  logic [PAYLOAD_W-1:0] payload,
   output logic                 hold,
   output logic                 ok,
   output logic [PAYLOAD_W-1:0] rel_payload
);

   lane_state_t          state_q;
   lane_state_t          state_d;
   logic                 capture;
   logic [PAYLOAD_W-1:0] hold_buf;

   // Lane state register; reset returns the lane to IDLE
   always_ff @(posedge clk) begin
      if (reset) state_q <= LS_IDLE;
      else       state_q <= state_d;
   end

   // Next state and capture strobe; flush and group acceptance both end the lane's group
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      if (flush || grp_ready) begin
         state_d = LS_IDLE;
      end else begin
         case (state_q)
            LS_IDLE, LS_WAIT_SELF: begin
               if (valid && done) begin
                  state_d = LS_HELD;
                  capture = 1'b1;
               end else if (valid) begin
                  state_d = LS_WAIT_SELF;
               end else begin
                  state_d = LS_IDLE;
               end
            end
            LS_HELD: state_d = LS_HELD;
            default: state_d = LS_IDLE;
         endcase
      end
   end

   // Capture buffer: loaded once when the lane finishes ahead of its group
   always_ff @(posedge clk) begin
      if (reset)        hold_buf <= '0;
      else if (capture) hold_buf <= payload;
   end

   assign hold        = (state_q == LS_HELD);
   assign ok          = ~valid | done | hold;
   assign rel_payload = hold ? hold_buf : payload;

endmodule

// File: rtl/exm_lane_sync.sv
// N-lane completion barrier between the EXM lanes and WB, with stall counters.
// One cycle from group acceptance to the registered WB output.
// WB backpressure (ws_ready low) freezes the output register and keeps finished lanes held.
module exm_lane_sync
   import exm_lane_sync_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int PAYLOAD_W = PAYLOAD_W_DEF,
   parameter int CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [LANES-1:0]           lane_valid,
   input  logic [LANES-1:0]           lane_done,
   input  logic [LANES*PAYLOAD_W-1:0] lane_payload,
   output logic [LANES-1:0]           lane_hold,
   output logic                       grp_ready,
   input  logic                       ws_ready,
   output logic [LANES-1:0]           ws_valid,
   output logic                       ws_fire,
   output logic [LANES*PAYLOAD_W-1:0] ws_payload,
   output logic [CNT_W-1:0]           stall_cur,
   output logic [CNT_W-1:0]           stall_total
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [LANES-1:0]           lane_ok;
   logic [LANES*PAYLOAD_W-1:0] rel_payload;
   logic                       grp_done;
   logic                       stall_inc;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      exm_lane_slot #(
         .PAYLOAD_W (PAYLOAD_W)
      ) u_slot (
         .clk         (clk),
         .reset       (reset),
         .flush       (flush),
         .grp_ready   (grp_ready),
         .valid       (lane_valid[i]),
         .done        (lane_done[i]),
         .payload     (lane_payload[i*PAYLOAD_W +: PAYLOAD_W]),
         .hold        (lane_hold[i]),
         .ok          (lane_ok[i]),
         .rel_payload (rel_payload[i*PAYLOAD_W +: PAYLOAD_W])
      );
   end

   // Lanes without a valid instruction never block the group; WB stalls are not lane stalls
   assign grp_done  = &lane_ok;
   assign grp_ready = grp_done & ws_ready & ~flush;
   assign stall_inc = ~flush & ~grp_done & (|lane_valid);

   // WB output register: flush kills it regardless of ws_ready, otherwise it only moves on ws_ready
   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid   <= '0;
         ws_fire    <= 1'b0;
         ws_payload <= '0;
      end else if (flush) begin
         ws_valid   <= '0;
         ws_fire    <= 1'b0;
      end else if (ws_ready) begin
         ws_valid   <= grp_ready ? lane_valid : '0;
         ws_fire    <= grp_ready & (|lane_valid);
         ws_payload <= rel_payload;
      end
   end

   // Wait time of the group in flight; restarts on acceptance or flush, saturates
   always_ff @(posedge clk) begin
      if (reset)                    stall_cur <= '0;
      else if (grp_ready || flush)  stall_cur <= '0;
      else if (stall_inc && !(&stall_cur))
                                    stall_cur <= stall_cur + CNT_ONE;
   end

   // Cumulative lane stall cycles since reset, saturating
   always_ff @(posedge clk) begin
      if (reset)                            stall_total <= '0;
      else if (stall_inc && !(&stall_total)) stall_total <= stall_total + CNT_ONE;
   end

endmodule

// File: tb/tb_exm_lane_sync.sv
// Self-checking bench for exm_lane_sync: a 2-lane and a 4-lane instance.
// Expected releases are queued when stimulus completes a group and compared one cycle later.
// Directed cases cover early finish, invalid lanes, WB backpressure, flush, reset and saturation.
module tb_exm_lane_sync;

   localparam int PW = 117;

   typedef struct {
      logic [3:0]   v;
      logic [511:0] pl;
      logic [511:0] mask;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;

   logic [1:0]      v2, d2, hold2, wsv2;
   logic [2*PW-1:0] p2, wsp2;
   logic            r2, grp2, fire2;
   logic [15:0]     cur2, tot2;

   logic [3:0]      v4, d4, hold4, wsv4;
   logic [4*PW-1:0] p4, wsp4;
   logic            r4, grp4, fire4;
   logic [15:0]     cur4, tot4;

   int   checks = 0;
   int   errors = 0;
   exp_t q2[$];
   exp_t q4[$];
   exp_t e2, e4;
   logic pend2 = 1'b0, pend2_fire = 1'b0;
   logic pend4 = 1'b0, pend4_fire = 1'b0;

   always #5 clk = ~clk;

   exm_lane_sync #(.LANES(2), .PAYLOAD_W(PW), .CNT_W(16)) dut2 (
      .clk(clk), .reset(reset), .flush(flush),
      .lane_valid(v2), .lane_done(d2), .lane_payload(p2),
      .lane_hold(hold2), .grp_ready(grp2), .ws_ready(r2),
      .ws_valid(wsv2), .ws_fire(fire2), .ws_payload(wsp2),
      .stall_cur(cur2), .stall_total(tot2)
   );

   exm_lane_sync #(.LANES(4), .PAYLOAD_W(PW), .CNT_W(16)) dut4 (
      .clk(clk), .reset(reset), .flush(flush),
      .lane_valid(v4), .lane_done(d4), .lane_payload(p4),
      .lane_hold(hold4), .grp_ready(grp4), .ws_ready(r4),
      .ws_valid(wsv4), .ws_fire(fire4), .ws_payload(wsp4),
      .stall_cur(cur4), .stall_total(tot4)
   );

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] rnd_pl();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[PW-1:0];
   endfunction

   task automatic push2(input logic [1:0] v, input logic [2*PW-1:0] pl);
      exp_t e;
      e.v = {2'b00, v};
      e.pl = '0;
      e.pl[2*PW-1:0] = pl;
      e.mask = '0;
      for (int i = 0; i < 2; i++) if (v[i]) e.mask[i*PW +: PW] = '1;
      q2.push_back(e);
   endtask

   task automatic push4(input logic [3:0] v, input logic [4*PW-1:0] pl);
      exp_t e;
      e.v = v;
      e.pl = '0;
      e.pl[4*PW-1:0] = pl;
      e.mask = '0;
      for (int i = 0; i < 4; i++) if (v[i]) e.mask[i*PW +: PW] = '1;
      q4.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // 2-lane scoreboard: a cycle with grp_ready must show up in the output register one cycle later
   always @(negedge clk) begin
      if (reset) begin
         pend2 = 1'b0;
      end else begin
         if (pend2) begin
            if (pend2_fire) begin
               chk("q2_nonempty", q2.size() != 0, 1);
               if (q2.size() != 0) begin
                  e2 = q2.pop_front();
                  chk("ws_valid2", wsv2, e2.v);
                  chk("ws_fire2", fire2, 1);
                  chk("ws_payload2", wsp2 & e2.mask[2*PW-1:0], e2.pl[2*PW-1:0] & e2.mask[2*PW-1:0]);
               end
            end else begin
               chk("bubble_valid2", wsv2, 0);
               chk("bubble_fire2", fire2, 0);
            end
         end
         pend2      = grp2;
         pend2_fire = |v2;
      end
   end

   // 4-lane scoreboard, same rule
   always @(negedge clk) begin
      if (reset) begin
         pend4 = 1'b0;
      end else begin
         if (pend4) begin
            if (pend4_fire) begin
               chk("q4_nonempty", q4.size() != 0, 1);
               if (q4.size() != 0) begin
                  e4 = q4.pop_front();
                  chk("ws_valid4", wsv4, e4.v);
                  chk("ws_fire4", fire4, 1);
                  chk("ws_payload4", wsp4 & e4.mask[4*PW-1:0], e4.pl[4*PW-1:0] & e4.mask[4*PW-1:0]);
               end
            end else begin
               chk("bubble_valid4", wsv4, 0);
               chk("bubble_fire4", fire4, 0);
            end
         end
         pend4      = grp4;
         pend4_fire = |v4;
      end
   end

   initial begin
      logic [PW-1:0] a, b, c;
      logic [PW-1:0] lp[4];
      logic [PW-1:0] ex[4];
      int            ord[4];
      ord = '{3, 1, 0, 2};

      reset = 1'b1; flush = 1'b0;
      v2 = '0; d2 = '0; p2 = '0; r2 = 1'b1;
      v4 = '0; d4 = '0; p4 = '0; r4 = 1'b1;
      tick(); tick();
      reset = 1'b0;
      mid();
      chk("rst_ws_valid", wsv2, 0);
      chk("rst_ws_fire", fire2, 0);
      chk("rst_ws_payload", wsp2, 0);
      chk("rst_stall_cur", cur2, 0);
      chk("rst_stall_total", tot2, 0);
      chk("rst_lane_hold", hold2, 0);
      chk("rst_grp_ready", grp2, 1);
      chk("rst_ws_payload4", wsp4, 0);
      tick();

      // Both lanes finish together: released the same cycle, live payload passes through
      a = rnd_pl(); b = rnd_pl();
      v2 = 2'b11; d2 = 2'b11; p2 = {b, a};
      mid();
      chk("t1_grp_ready", grp2, 1);
      push2(2'b11, {b, a});
      tick();
      v2 = '0; d2 = '0;
      mid();
      chk("t1_stall_cur", cur2, 0);
      tick();

      // Lane0 early with 0xA5, lane1 done three cycles later; buffered value survives live change
      a = 117'hA5; b = rnd_pl();
      v2 = 2'b11; d2 = 2'b01; p2 = {b, a};
      mid();
      chk("t2_grp_ready_c0", grp2, 0);
      tick();
      for (int cyc = 1; cyc <= 3; cyc++) begin
         b = rnd_pl();
         d2 = (cyc == 3) ? 2'b10 : 2'b00;
         p2 = {b, {PW{1'b0}}};
         mid();
         chk("t2_lane_hold", hold2, 2'b01);
         if (cyc == 3) begin
            chk("t2_grp_ready_c3", grp2, 1);
            chk("t2_stall_cur", cur2, 3);
            push2(2'b11, {b, a});
         end else begin
            chk("t2_grp_ready_wait", grp2, 0);
         end
         tick();
      end
      v2 = '0; d2 = '0;
      mid();
      chk("t2_stall_total", tot2, 3);
      chk("t2_hold_cleared", hold2, 0);
      tick();

      // Lane1 invalid, lane0 finishes on cycle 2
      a = rnd_pl(); b = rnd_pl();
      v2 = 2'b01; d2 = 2'b00; p2 = {b, a};
      mid();
      chk("t3_grp_ready_c0", grp2, 0);
      tick();
      mid();
      chk("t3_grp_ready_c1", grp2, 0);
      tick();
      d2 = 2'b01;
      mid();
      chk("t3_grp_ready_c2", grp2, 1);
      push2(2'b01, {b, a});
      tick();

      // Both finish while WB stalls 4 cycles: output frozen, counters frozen, buffers used on release
      a = rnd_pl(); b = rnd_pl();
      v2 = 2'b11; d2 = 2'b11; p2 = {b, a}; r2 = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (cyc > 0) p2 = {rnd_pl(), rnd_pl()};
         mid();
         chk("t4_grp_ready", grp2, 0);
         chk("t4_ws_valid_held", wsv2, 2'b01);
         chk("t4_ws_fire_held", fire2, 1);
         chk("t4_stall_total", tot2, 5);
         if (cyc > 0) chk("t4_lane_hold", hold2, 2'b11);
         tick();
      end
      r2 = 1'b1; p2 = {rnd_pl(), rnd_pl()};
      mid();
      chk("t4_release", grp2, 1);
      push2(2'b11, {b, a});
      tick();

      // Lane0 held, flush (with WB stalled) while lane1 completes: group discarded
      a = rnd_pl(); b = rnd_pl();
      v2 = 2'b11; d2 = 2'b01; p2 = {b, a};
      mid();
      chk("t5_grp_ready_c0", grp2, 0);
      tick();
      d2 = 2'b10; flush = 1'b1; r2 = 1'b0;
      mid();
      chk("t5_grp_ready_flush", grp2, 0);
      chk("t5_hold_before", hold2, 2'b01);
      tick();
      flush = 1'b0; r2 = 1'b1; v2 = '0; d2 = '0;
      mid();
      chk("t5_ws_valid", wsv2, 0);
      chk("t5_ws_fire", fire2, 0);
      chk("t5_stall_cur", cur2, 0);
      chk("t5_lane_hold", hold2, 0);
      chk("t5_stall_total", tot2, 6);
      tick();

      // Reset while lane0 is held: its buffer is discarded, the next group uses fresh payloads
      a = rnd_pl(); b = rnd_pl();
      v2 = 2'b11; d2 = 2'b01; p2 = {b, a};
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      b = rnd_pl(); c = rnd_pl();
      v2 = 2'b11; d2 = 2'b11; p2 = {b, c};
      mid();
      chk("t6_lane_hold", hold2, 0);
      chk("t6_stall_total", tot2, 0);
      chk("t6_grp_ready", grp2, 1);
      push2(2'b11, {b, c});
      tick();
      v2 = '0; d2 = '0;
      tick();

      // 4 lanes finishing in order 3,1,0,2: one release on cycle 3 with each lane's own payload
      v4 = 4'hF;
      for (int cyc = 0; cyc < 4; cyc++) begin
         d4 = 4'b0001 << ord[cyc];
         for (int l = 0; l < 4; l++) begin
            lp[l] = rnd_pl();
            p4[l*PW +: PW] = lp[l];
         end
         ex[ord[cyc]] = lp[ord[cyc]];
         mid();
         if (cyc < 3) begin
            chk("t7_grp_ready_wait", grp4, 0);
         end else begin
            chk("t7_grp_ready_c3", grp4, 1);
            chk("t7_lane_hold", hold4, 4'b1011);
            chk("t7_stall_cur", cur4, 3);
            push4(4'hF, {ex[3], ex[2], ex[1], ex[0]});
         end
         tick();
      end

      // Withhold done long enough to saturate both counters
      v4 = 4'b0001; d4 = 4'b0000;
      for (int n = 0; n < 70000; n++) tick();
      mid();
      chk("t8_stall_cur_sat", cur4, 16'hFFFF);
      chk("t8_stall_total_sat", tot4, 16'hFFFF);
      chk("t8_grp_ready", grp4, 0);
      tick();
      a = rnd_pl();
      d4 = 4'b0001; p4 = '0; p4[PW-1:0] = a;
      mid();
      chk("t8_release", grp4, 1);
      push4(4'b0001, {{(3*PW){1'b0}}, a});
      tick();
      v4 = '0; d4 = '0;
      mid();
      chk("t8_stall_cur_clr", cur4, 0);
      chk("t8_stall_total_kept", tot4, 16'hFFFF);
      tick();
      tick();

      mid();
      chk("q2_drained", q2.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exm_lane_sync.md
Name: exm_lane_sync

Overview:
- N-lane completion barrier between the EXM lanes and WB in the multi-issue core; generalises the two-lane my_ok/another_ok pairing to LANES lanes.
- Each lane raises done when its result is final. A lane that finishes early has its payload captured and is told to hold, so no repeated mem/div side effects.
- The issue group is released to WB only when every valid lane is complete. The block also provides WB backpressure, flush, and stall performance counters.

Parameters:
- LANES, 2, number of issue lanes (1..4).
- PAYLOAD_W, 117, per-lane ES->WS payload width ({csr_wen, csr_addr, csr_wdata, gr_we, dest, result, pc}).
- CNT_W, 16, width of the stall counters (saturating).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (exception/etrn/mispredict); kills the current group
- lane_valid  in  LANES  lane holds a valid instruction this cycle
- lane_done  in  LANES  lane result final this cycle (per-lane my_ok)
- lane_payload  in  LANES*PAYLOAD_W  live per-lane payload, lane i at [i*PAYLOAD_W +: PAYLOAD_W]
- lane_hold  out  LANES  lane already captured; lane must gate its mem/div requests (cal_valid)
- grp_ready  out  1  group accepted this cycle; upstream may advance
- ws_ready  in  1  WB accepts the output register
- ws_valid  out  LANES  per-lane valid of the registered group
- ws_fire  out  1  registered group is a real (non-bubble) group
- ws_payload  out  LANES*PAYLOAD_W  registered group payload
- stall_cur  out  CNT_W  cycles the current group has waited
- stall_total  out  CNT_W  cumulative stall cycles since reset

Behaviour:
- Per-lane FSM, states IDLE, WAIT_SELF, HELD. Reset and flush force every lane to IDLE.
- lane_ok[i] = ~lane_valid[i] | lane_done[i] | (state[i]==HELD). grp_done = &lane_ok.
- grp_ready = grp_done & ws_ready & ~flush.
- Lane transitions:
  - IDLE/WAIT_SELF, valid & ~done & ~grp_ready -> WAIT_SELF.
  - IDLE/WAIT_SELF, valid & done & ~grp_ready -> HELD; lane_payload[i] is captured into buf[i] that cycle.
  - Any state with grp_ready -> IDLE.
- HELD lanes keep buf[i]; a changing live lane_payload[i] has no effect. lane_hold[i] = (state[i]==HELD).
- Release payload per lane = HELD ? buf[i] : live lane_payload[i]. A lane done in the same cycle as release passes through live, with no capture.
- Output register, one cycle latency:
  - On ws_ready: ws_valid <= grp_ready ? lane_valid : 0; ws_fire <= grp_ready & |lane_valid; ws_payload <= release payload.
  - On ~ws_ready: output register holds its value.
  - An invalid lane inside a released group has ws_valid=0; its payload is don't-care.
- Flush has priority over completion. The group is discarded, all ws_valid <= 0, ws_fire <= 0, and stall_cur <= 0 the same cycle, whether ws_ready is high or low.
- stall_cur: cleared when grp_ready or flush; otherwise +1 when any lane_valid & ~grp_done. Saturates at all-ones.
- stall_total: +1 under the same condition as stall_cur. Saturating; cleared only by reset.
- A cycle with grp_done & ~ws_ready is a WB stall. It is not counted as a lane stall, and no capture occurs for lanes already HELD.
- Reset values: all lane states IDLE, buf = 0, ws_valid = 0, ws_fire = 0, ws_payload = 0, stall_cur = 0, stall_total = 0, lane_hold = 0. grp_ready then follows its combinational definition.
- A reset asserted mid-wait discards captured buffers; no output is produced for that group.
- With LANES=1 the block degenerates to a registered stage. HELD is still entered if ws_ready is low when done is asserted.

Decomposition:
- Shared package/define.vh: lane FSM state encodings (LS_IDLE=2'b00, LS_WAIT_SELF=2'b01, LS_HELD=2'b10), and a PAYLOAD_W default tied to `ES_TO_WS_BUS_WD.
- One natural sub-module, exm_lane_slot: per-lane FSM plus capture buffer, generated LANES times.
- The barrier reduction, output register and counters stay in the top.

Test Plan:
- LANES=2, both valid, both done cycle 0, ws_ready=1 -> grp_ready=1 cycle 0; cycle 1 ws_valid=2'b11, ws_fire=1, payloads equal live inputs; stall_cur=0.
- Lane0 done cycle 0 with payload 0xA5, lane1 done cycle 3 -> lane_hold[0]=1 cycles 1-3; release cycle 3; ws_payload lane0=0xA5 even though live input changed to 0x00; stall_total=3.
- Lane1 invalid, lane0 done after 2 cycles -> released cycle 2, ws_valid=2'b01.
- Both done, ws_ready=0 for 4 cycles -> grp_ready=0, output register held, stall_total unchanged; release on the first ws_ready=1 cycle.
- Lane0 HELD, flush while lane1 completes -> no release, lane_hold=0 next cycle, ws_valid=0, stall_cur=0.
- LANES=4, done in order 3,1,0,2 on cycles 0-3 -> single release cycle 3 with ws_valid=4'hF; stall_cur saturates at 0xFFFF when done is withheld 70000 cycles.
